// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch front end.
//   NOP_INSTR         instruction presented when no entry is valid
//   DEFAULT_RESET_PC  default first fetch address after reset
//   DEFAULT_BUF_DEPTH default skid-buffer depth / credit limit
//   CNT_W             width of occupancy/credit counters for the default depth
//   entry_t           {pc, instr} record held in the skid buffer
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam int unsigned DEFAULT_BUF_DEPTH = 2;
    localparam int unsigned CNT_W             = $clog2(DEFAULT_BUF_DEPTH + 1);
    localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small in-order FIFO built as a shift register so the head
// entry is always slot 0, i.e. a direct register output.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   push, din   write din at the tail (ignored when full without a pop)
//   pop         remove the head (ignored when empty); legal with push
//   flush       empty the FIFO; overrides push and pop
//   head        slot 0; holds EMPTY_VAL whenever the FIFO is empty
//   count       number of stored entries
//   not_empty   registered count != 0
module fetch_buffer #(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [WIDTH-1:0]  EMPTY_VAL = '0,
    parameter int unsigned       CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             not_empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             pop_eff;
    logic             push_eff;

    // Next contents: shift on pop, then write at the post-pop tail.
    // Slots beyond count always hold EMPTY_VAL.
    always_comb begin
        pop_eff  = pop && (count != '0);
        push_eff = push && ((count != CNT_W'(DEPTH)) || pop_eff);
        wr_idx   = count - CNT_W'(pop_eff);
        count_d  = count - CNT_W'(pop_eff) + CNT_W'(push_eff);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (pop_eff) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = EMPTY_VAL;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push_eff && (wr_idx == CNT_W'(i))) begin
                mem_d[i] = din;
            end
        end
        if (flush) begin
            count_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_d[i] = EMPTY_VAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            not_empty <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= EMPTY_VAL;
            end
        end else begin
            count     <= count_d;
            not_empty <= (count_d != '0);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head = mem_q[0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential-PC instruction fetch feeding the IF_ID register.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   imem_req_valid/ready/addr           fetch request channel (valid is
//                                       combinational from state + redirect)
//   imem_rsp_valid/data                 in-order instruction responses
//   redirect_valid, redirect_pc         control-flow change from EX
//   stall                               IF_ID hold; backpressure on the head
//   pc_out, instruction_out, valid_out  registered head of the skid buffer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = OCC_W + 1;
    localparam logic [ENTRY_W-1:0] EMPTY_ENTRY = ENTRY_W'({32'h0000_0000, NOP_INSTR});

    logic [31:0]      fetch_pc_q;
    logic [31:0]      fetch_pc_d;
    logic [OCC_W-1:0] discard_q;
    logic [OCC_W-1:0] discard_d;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] outstanding;
    logic [SUM_W-1:0] credit_used;
    logic [31:0]      req_pc_head;
    logic             req_pending;
    logic             req_fire;
    logic             rsp_take;
    logic             rsp_drop;
    logic             rsp_keep;
    logic             head_pop;
    entry_t           buf_din;
    entry_t           buf_head;

    // Credits cover both buffered entries and in-flight requests, so every
    // response always has a free buffer slot.
    assign credit_used    = SUM_W'(outstanding) + SUM_W'(occupancy);
    assign imem_req_valid = rst_n && !redirect_valid && (credit_used < SUM_W'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_take = imem_rsp_valid && req_pending;
    assign rsp_drop = rsp_take && (discard_q != '0);
    assign rsp_keep = rsp_take && (discard_q == '0);
    assign head_pop = valid_out && !stall;
    assign buf_din  = '{pc: req_pc_head, instr: imem_rsp_data};

    // Request-PC FIFO: its count is the outstanding-request count; stale
    // entries drain with the discarded responses.
    fetch_buffer #(
        .WIDTH     (32),
        .DEPTH     (BUF_DEPTH),
        .EMPTY_VAL (32'h0000_0000),
        .CNT_W     (OCC_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .pop       (rsp_take),
        .flush     (1'b0),
        .din       (fetch_pc_q),
        .head      (req_pc_head),
        .count     (outstanding),
        .not_empty (req_pending)
    );

    // Skid buffer: head drives the IF_ID outputs directly.
    fetch_buffer #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (BUF_DEPTH),
        .EMPTY_VAL (EMPTY_ENTRY),
        .CNT_W     (OCC_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .pop       (head_pop),
        .flush     (redirect_valid),
        .din       (buf_din),
        .head      (buf_head),
        .count     (occupancy),
        .not_empty (valid_out)
    );

    assign pc_out          = buf_head.pc;
    assign instruction_out = buf_head.instr;

    // Fetch PC and discard bookkeeping; a redirect overrides both. After a
    // redirect every request still in flight past this cycle is stale.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_drop) begin
            discard_d = discard_q - OCC_W'(1);
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & PC_ALIGN_MASK;
            discard_d  = outstanding - OCC_W'(rsp_take);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

endmodule
